// File: rtl/uart_transmit_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_transmit_if;
  logic [7:0] dataInput;
  logic       dataValid;
  logic       dataReady;

  modport master (output dataInput, output dataValid, input dataReady);
  modport slave  (input dataInput, input dataValid, output dataReady);
endinterface

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent back to back
// while bytes remain queued.
module uart_transmit #(
  parameter int BIT_CLKS   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_transmit_if.slave   tx_if,
  output logic             txd,
  output logic             busy,
  output logic [31:0]      sentCount
);

  localparam int             AW   = $clog2(FIFO_DEPTH);
  localparam logic [15:0]    LAST = 16'(BIT_CLKS - 1);
  localparam logic [AW:0]    FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_bit, w_bit_nx, w_bit_p1;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_txd, w_txd_nx;
  logic [31:0] r_sent_count;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  logic w_push, w_pop, w_empty, w_sent_inc;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign w_empty         = (r_count == '0);
  assign tx_if.dataReady = (r_count != FULL);
  assign w_push          = tx_if.dataValid & tx_if.dataReady;

  assign txd       = r_txd;
  assign busy      = (r_state != IDLE) | ~w_empty;
  assign sentCount = r_sent_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= tx_if.dataInput;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_txd        <= 1'b1;
      r_sent_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_txd   <= w_txd_nx;
      if (w_sent_inc) r_sent_count <= r_sent_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 16'd1;
    w_bit_nx   = r_bit;
    w_bit_p1   = r_bit + 3'd1;
    w_shift_nx = r_shift;
    w_txd_nx   = r_txd;
    w_pop      = 1'b0;
    w_sent_inc = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nx = 1'b1;
        w_cnt_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rptr];
          w_txd_nx   = 1'b0;
          w_state_nx = START;
        end
      end
      START: begin
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
          w_txd_nx   = r_shift[0];
          w_state_nx = DATA;
        end
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nx = '0;
          if (r_bit == 3'd7) begin
            w_txd_nx   = 1'b1;
            w_state_nx = STOP;
          end else begin
            w_bit_nx = w_bit_p1;
            w_txd_nx = r_shift[w_bit_p1];
          end
        end
      end
      STOP: begin
        // A queued byte goes straight into the next start bit with no idle gap.
        if (r_cnt == LAST) begin
          w_cnt_nx   = '0;
          w_sent_inc = 1'b1;
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_mem[r_rptr];
            w_txd_nx   = 1'b0;
            w_state_nx = START;
          end else begin
            w_txd_nx   = 1'b1;
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: frame-level reference model compared every cycle,
// plus directed checks of latency, back-pressure, mid-frame reset and counter wrap.
module tb_uart_transmit;
  localparam int BC = 4;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        txd, busy;
  logic [31:0] sentCount;

  uart_transmit_if bus ();

  uart_transmit #(.BIT_CLKS(BC), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_if     (bus.slave),
    .txd       (txd),
    .busy      (busy),
    .sentCount (sentCount)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a queue of waiting bytes and a cycle index into the current frame.
  logic [7:0]  m_q [$];
  bit          m_infr = 1'b0;
  int          m_c    = 0;
  logic [7:0]  m_cur  = 8'h00;
  logic [31:0] m_sent = 32'd0;
  int          m_acc  = 0;
  logic [31:0] bias   = 32'd0;
  bit          m_take;
  logic [7:0]  m_din;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_infr = 1'b0;
      m_c    = 0;
      m_sent = 32'd0;
    end else begin
      m_take = bus.dataValid && (m_q.size() < D);
      m_din  = bus.dataInput;
      if (m_infr) begin
        m_c++;
        if (m_c == 10 * BC) begin
          m_sent++;
          m_infr = 1'b0;
        end
      end
      if (!m_infr && m_q.size() > 0) begin
        m_cur  = m_q.pop_front();
        m_infr = 1'b1;
        m_c    = 0;
      end
      if (m_take) begin
        m_q.push_back(m_din);
        m_acc++;
      end
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_infr) return 1'b1;
    k = m_c / BC;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    check("txd",       {31'd0, txd},           {31'd0, exp_txd()});
    check("busy",      {31'd0, busy},          {31'd0, (m_infr || m_q.size() > 0)});
    check("dataReady", {31'd0, bus.dataReady}, {31'd0, (m_q.size() < D)});
    check("sentCount", sentCount,              m_sent + bias);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk_all();
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((m_infr || m_q.size() > 0) && n < lim) begin
      tick();
      n++;
    end
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [9:0]  fr;
  logic [7:0]  vals [6];
  int          idx, acc_prev;
  logic [31:0] sent_prev;
  bit          seen_full, seen_pop;

  initial begin
    bus.dataValid = 1'b0;
    bus.dataInput = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd",   {31'd0, txd},           32'd1);
    check("rst_busy",  {31'd0, busy},          32'd0);
    check("rst_ready", {31'd0, bus.dataReady}, 32'd1);
    check("rst_sent",  sentCount,              32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // Single 0xA5 frame from idle; start bit must appear one edge after acceptance.
    bus.dataInput = 8'hA5;
    bus.dataValid = 1'b1;
    tick();
    bus.dataValid = 1'b0;
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * BC; k++) begin
      tick();
      check("a5_line", {31'd0, txd}, {31'd0, fr[k / BC]});
    end
    tick();
    check("a5_busy", {31'd0, busy}, 32'd0);
    check("a5_sent", sentCount, 32'd1);

    // Back-to-back 0x00 then 0xFF.
    bus.dataValid = 1'b1;
    bus.dataInput = 8'h00;
    tick();
    bus.dataInput = 8'hFF;
    tick();
    bus.dataValid = 1'b0;
    drain(200);
    check("b2b_sent", sentCount, 32'd3);

    // Six bytes under continuous dataValid: FIFO fills, then the last waits for a pop.
    for (int i = 0; i < 6; i++) vals[i] = 8'($urandom);
    idx = 0;
    acc_prev = m_acc;
    sent_prev = sentCount;
    seen_full = 1'b0;
    seen_pop = 1'b0;
    bus.dataInput = vals[0];
    bus.dataValid = 1'b1;
    for (int n = 0; n < 400 && idx < 6; n++) begin
      tick();
      if (idx == 5 && !seen_pop && sentCount != sent_prev) begin
        seen_pop = 1'b1;
        check("pop_full_no_push", {31'd0, bus.dataReady}, 32'd1);
      end
      if (m_acc != acc_prev) begin
        acc_prev = m_acc;
        idx++;
        if (idx < 6) bus.dataInput = vals[idx];
        else bus.dataValid = 1'b0;
        if (idx == 5 && !seen_full) begin
          seen_full = 1'b1;
          check("full_ready", {31'd0, bus.dataReady}, 32'd0);
        end
      end
    end
    check("six_accepted", 32'(idx), 32'd6);
    bus.dataValid = 1'b0;
    drain(600);
    check("six_sent", sentCount, 32'd9);

    // Random traffic.
    for (int n = 0; n < 120; n++) begin
      bus.dataValid = 1'($urandom_range(0, 1));
      bus.dataInput = 8'($urandom);
      tick();
    end
    bus.dataValid = 1'b0;
    drain(800);

    // Reset in the middle of data bit 3 with more bytes queued behind the frame.
    bus.dataValid = 1'b1;
    bus.dataInput = 8'h34;
    tick();
    bus.dataInput = 8'h5A;
    tick();
    bus.dataInput = 8'hC3;
    tick();
    bus.dataValid = 1'b0;
    repeat (15) tick();
    check("bit3_line", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_txd",   {31'd0, txd},           32'd1);
    check("mid_rst_busy",  {31'd0, busy},          32'd0);
    check("mid_rst_ready", {31'd0, bus.dataReady}, 32'd1);
    check("mid_rst_sent",  sentCount,              32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) tick();
    check("post_rst_sent", sentCount, 32'd0);
    check("post_rst_txd",  {31'd0, txd}, 32'd1);

    // Counter wrap from a forced all-ones value.
    force dut.r_sent_count = 32'hFFFF_FFFF;
    bias = 32'hFFFF_FFFF;
    #1;
    release dut.r_sent_count;
    tick();
    check("preload", sentCount, 32'hFFFF_FFFF);
    bus.dataValid = 1'b1;
    bus.dataInput = 8'h81;
    tick();
    bus.dataValid = 1'b0;
    drain(100);
    check("wrap", sentCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
